// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM encoding and frame constants.
package uart_pkg;

  localparam int unsigned UART_MIN_CPB   = 4;
  localparam int unsigned UART_DATA_BITS = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_rx_state_e;

endpackage

// File: rtl/uart_bit_sync.sv
// N-flop synchroniser for an asynchronous single-bit input, with a selectable reset level.
module uart_bit_sync #(
  parameter int unsigned N = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic rst_val_i,
  input  logic d_i,
  output logic q_o
);

  logic [N-1:0] sync_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= {N{rst_val_i}};
    end else begin
      sync_q <= {sync_q[N-2:0], d_i};
    end
  end

  assign q_o = sync_q[N-1];

endmodule

// File: rtl/uart_rx_frontend.sv
// UART 8N1 receive front end: pin synchroniser, start-bit qualification, mid-bit sampling,
// framing-error and line-break detection.
module uart_rx_frontend
  import uart_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_CPB     = UART_MIN_CPB
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic [15:0] clks_per_bit_i,
  input  logic        rx_i,
  output logic [7:0]  byte_o,
  output logic        valid_o,
  output logic        sbit_o,
  output logic        frame_err_o,
  output logic        break_o
);

  uart_rx_state_e state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [15:0]    cpb_q, cpb_d;
  logic [2:0]     bit_idx_q, bit_idx_d;
  logic [7:0]     shift_q, shift_d;
  logic [7:0]     byte_q, byte_d;
  logic           valid_q, valid_d;
  logic           ferr_q, ferr_d;
  logic           brk_q, brk_d;
  logic           sbit_c;
  logic           rx_s;
  logic [15:0]    half;

  uart_bit_sync #(.N(SYNC_STAGES)) u_rx_sync (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .rst_val_i (1'b1),
    .d_i       (rx_i),
    .q_o       (rx_s)
  );

  assign half = cpb_q >> 1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      cpb_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      byte_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      cpb_q     <= cpb_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      byte_q    <= byte_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      brk_q     <= brk_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cpb_d     = cpb_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    byte_d    = byte_q;
    valid_d   = 1'b0;
    ferr_d    = 1'b0;
    brk_d     = brk_q;
    sbit_c    = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        // A held break keeps the line low; it must not be taken as a new start.
        if (en_i && !rx_s && !brk_q && (clks_per_bit_i >= 16'(MIN_CPB))) begin
          state_d = START;
          cpb_d   = clks_per_bit_i;
        end
      end
      START: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == half - 16'd1) begin
          cnt_d = '0;
          if (!rx_s) begin
            sbit_c  = 1'b1;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == cpb_q - 16'd1) begin
          cnt_d     = '0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'(UART_DATA_BITS - 1)) begin
            state_d = STOP;
          end
        end
      end
      STOP: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == cpb_q - 16'd1) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            byte_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
            if (shift_q == 8'h00) begin
              brk_d = 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (rx_s) begin
      brk_d = 1'b0;
    end

    // Disabling abandons the frame silently and drops any break indication.
    if (!en_i) begin
      state_d   = IDLE;
      cnt_d     = '0;
      bit_idx_d = '0;
      shift_d   = '0;
      byte_d    = byte_q;
      valid_d   = 1'b0;
      ferr_d    = 1'b0;
      brk_d     = 1'b0;
      sbit_c    = 1'b0;
    end
  end

  assign byte_o      = byte_q;
  assign valid_o     = valid_q;
  assign frame_err_o = ferr_q;
  assign sbit_o      = sbit_c;
  assign break_o     = brk_q & ~rx_s;

endmodule

// File: tb/tb_uart_rx_frontend.sv
// Scoreboard bench for uart_rx_frontend: directed frames push expected pulses, a monitor pops and checks them.
module tb_uart_rx_frontend;
  import uart_pkg::*;

  localparam int SYNC = 2;

  logic        clk_i;
  logic        rst_i;
  logic        en_i;
  logic [15:0] clks_per_bit_i;
  logic        rx_i;
  logic [7:0]  byte_o;
  logic        valid_o;
  logic        sbit_o;
  logic        frame_err_o;
  logic        break_o;

  typedef struct {
    int          kind;
    logic [7:0]  data;
    int unsigned cyc;
    logic        brk;
  } exp_t;

  exp_t        exp_q[$];
  int          n_vec;
  int          n_err;
  int unsigned cyc;
  logic [7:0]  last_byte;

  uart_rx_frontend #(.SYNC_STAGES(SYNC), .MIN_CPB(4)) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .en_i           (en_i),
    .clks_per_bit_i (clks_per_bit_i),
    .rx_i           (rx_i),
    .byte_o         (byte_o),
    .valid_o        (valid_o),
    .sbit_o         (sbit_o),
    .frame_err_o    (frame_err_o),
    .break_o        (break_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  // Monitor: every output pulse is matched against the oldest expected event.
  always @(negedge clk_i) begin
    int   pulses;
    int   kind;
    exp_t e;
    pulses = int'(valid_o) + int'(frame_err_o) + int'(sbit_o);
    if (pulses > 1) begin
      n_vec++;
      n_err++;
      $display("[TB] FAIL exclusive: got %0d simultaneous pulses expected at most 1 (cycle %0d)", pulses, cyc);
    end
    if (pulses != 0) begin
      kind = valid_o ? 1 : (frame_err_o ? 2 : 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("[TB] FAIL unexpected_pulse: got kind %0d byte 0x%0h expected no pulse (cycle %0d)", kind, byte_o, cyc);
      end else begin
        e = exp_q.pop_front();
        checkOutput("pulse_kind", 32'(kind), 32'(e.kind));
        checkOutput("pulse_cycle", 32'(cyc), 32'(e.cyc));
        checkOutput("pulse_byte", 32'(byte_o), 32'(e.data));
        if (kind == 2) checkOutput("break_on_ferr", 32'(break_o), 32'(e.brk));
      end
    end
  end

  // abort_mode: 0 none, 1 reset during data, 2 enable drop during data.
  task automatic applyStimulus(input logic [7:0] data, input logic stop_bit, input int cpb,
                               input int abort_mode, input bit jitter);
    int unsigned c;
    int unsigned h;
    exp_t e;
    c = cyc;
    h = cpb / 2;
    e.kind = 0; e.data = last_byte; e.cyc = c + SYNC + h; e.brk = 1'b0;
    exp_q.push_back(e);
    if (abort_mode == 0) begin
      e.cyc = c + SYNC + h + 9 * cpb + 1;
      if (stop_bit) begin
        e.kind = 1; e.data = data; last_byte = data;
      end else begin
        e.kind = 2; e.data = last_byte; e.brk = (data == 8'h00);
      end
      exp_q.push_back(e);
    end
    rx_i = 1'b0;
    tick(cpb);
    for (int i = 0; i < 8; i++) begin
      if (abort_mode != 0 && i == 3) begin
        rx_i = 1'b1;
        if (abort_mode == 1) begin
          rst_i = 1'b1;
          last_byte = 8'h00;
        end else begin
          en_i = 1'b0;
        end
        tick(3);
        rst_i = 1'b0;
        en_i  = 1'b1;
        return;
      end
      rx_i = data[i];
      if (jitter && i == 4) clks_per_bit_i = 16'd5;
      tick(cpb);
    end
    clks_per_bit_i = 16'(cpb);
    rx_i = stop_bit;
    tick(cpb);
    rx_i = 1'b1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion (cycle %0d)", cyc);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int unsigned c;
    n_vec = 0;
    n_err = 0;
    last_byte = 8'h00;
    rst_i = 1'b1;
    en_i = 1'b0;
    rx_i = 1'b1;
    clks_per_bit_i = 16'd16;
    repeat (3) @(negedge clk_i);
    checkOutput("rst_byte", 32'(byte_o), 32'h00);
    checkOutput("rst_valid", 32'(valid_o), 32'h0);
    checkOutput("rst_sbit", 32'(sbit_o), 32'h0);
    checkOutput("rst_ferr", 32'(frame_err_o), 32'h0);
    checkOutput("rst_break", 32'(break_o), 32'h0);
    checkOutput("rst_state", 32'(dut.state_q), 32'(IDLE));
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    en_i = 1'b1;
    tick(10);

    $display("[TB] good frame 0xA5, divisor changed mid-frame");
    applyStimulus(8'hA5, 1'b1, 16, 0, 1'b1);
    tick(32);
    checkOutput("a5_byte_hold", 32'(byte_o), 32'hA5);

    $display("[TB] 5-cycle start glitch");
    rx_i = 1'b0;
    tick(5);
    rx_i = 1'b1;
    tick(20);
    checkOutput("glitch_idle", 32'(dut.state_q), 32'(IDLE));

    $display("[TB] frame 0x3C with stop bit 0");
    applyStimulus(8'h3C, 1'b0, 16, 0, 1'b0);
    tick(32);
    checkOutput("ferr_byte_hold", 32'(byte_o), 32'hA5);
    checkOutput("ferr_no_break", 32'(break_o), 32'h0);

    $display("[TB] line break for 20 bit times");
    begin
      exp_t e;
      c = cyc;
      e.kind = 0; e.data = last_byte; e.cyc = c + SYNC + 8; e.brk = 1'b0;
      exp_q.push_back(e);
      e.kind = 2; e.cyc = c + SYNC + 8 + 144 + 1; e.brk = 1'b1;
      exp_q.push_back(e);
    end
    rx_i = 1'b0;
    tick(320);
    rx_i = 1'b1;
    @(negedge clk_i);
    @(negedge clk_i);
    checkOutput("break_held", 32'(break_o), 32'h1);
    @(negedge clk_i);
    checkOutput("break_cleared", 32'(break_o), 32'h0);
    @(posedge clk_i); #1;
    tick(40);

    $display("[TB] back-to-back 0x00, 0xFF at divisor 4");
    clks_per_bit_i = 16'd4;
    applyStimulus(8'h00, 1'b1, 4, 0, 1'b0);
    applyStimulus(8'hFF, 1'b1, 4, 0, 1'b0);
    tick(20);
    checkOutput("b2b_byte", 32'(byte_o), 32'hFF);

    $display("[TB] reset during frame 0x55, then 0x12");
    clks_per_bit_i = 16'd16;
    tick(4);
    applyStimulus(8'h55, 1'b1, 16, 1, 1'b0);
    tick(32);
    applyStimulus(8'h12, 1'b1, 16, 0, 1'b0);
    tick(32);

    $display("[TB] enable drop during frame 0x55, then 0x12");
    applyStimulus(8'h55, 1'b1, 16, 2, 1'b0);
    tick(32);
    applyStimulus(8'h12, 1'b1, 16, 0, 1'b0);
    tick(40);
    checkOutput("final_byte", 32'(byte_o), 32'h12);

    while (exp_q.size() != 0) begin
      exp_t e;
      e = exp_q.pop_front();
      n_vec++;
      n_err++;
      $display("[TB] FAIL missing_pulse: got none expected kind %0d at cycle %0d", e.kind, e.cyc);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
